asrv32_trap_ctrl: RTL
=====================

ASRV32_TRAP_CTRL -- requirements
Module: asrv32_trap_ctrl

Interface
REQ-001 SHALL have parameter TRAP_ADDRESS, default 0, fallback trap vector used when i_mtvec[31:2]==0.
REQ-002 SHALL have ports: i_clk  in  1  clock; i_rst  in  1  asynchronous active-high reset.
REQ-003 SHALL have ports: i_stage_valid  in  1  instruction valid in MEMORYACCESS; i_pc  in  32  its PC; i_instr  in  32  its encoding.
REQ-004 SHALL have ports: i_exc_inst_mis, i_exc_illegal, i_exc_ebreak, i_exc_ecall, i_exc_load_mis, i_exc_store_mis  in  1 each  exception flags; i_bad_addr  in  32  faulting address.
REQ-005 SHALL have ports: i_is_mret  in  1; i_irq  in  3  pending {meip,mtip,msip}; i_mie  in  3  enables {meie,mtie,msie}; i_mstatus, i_mtvec, i_mepc  in  32 each  current CSR values.
REQ-006 SHALL have ports: o_busy  out  1  core stall; o_csr_wr_en  out  1; o_csr_wr_sel  out  2  (0 MEPC, 1 MCAUSE, 2 MTVAL, 3 MSTATUS); o_csr_wr_data  out  32.
REQ-007 SHALL have ports: o_redirect_valid  out  1; o_redirect_pc  out  32; i_redirect_ack  in  1.

Function
REQ-008 SHALL implement FSM IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SAVE_STATUS, RESTORE_STATUS, REDIRECT; all outputs registered.
REQ-009 In IDLE with i_stage_valid=1, a request SHALL be taken when any exception flag is set, or (i_mstatus[3]=1 and |(i_irq & i_mie)), or i_is_mret; otherwise FSM stays IDLE.
REQ-010 Priority SHALL be: inst_mis(0) > illegal(2) > ebreak(3) > ecall(11) > load_mis(4) > store_mis(6) > MEI(11) > MSI(3) > MTI(7) > mret; lower-priority simultaneous events SHALL be dropped.
REQ-011 On taking a trap in cycle N, SHALL latch i_pc, cause code, interrupt bit, tval (i_bad_addr for misaligned, i_instr for illegal, 0 otherwise) and i_mstatus, and go to SAVE_EPC; o_busy SHALL be 1 from N+1 until the cycle after ack.
REQ-012 SAVE_EPC(N+1), SAVE_CAUSE(N+2), SAVE_TVAL(N+3), SAVE_STATUS(N+4) SHALL each assert o_csr_wr_en for exactly one cycle with sel 0/1/2/3; MCAUSE data = {intbit, 27'b0, code[3:0]}.
REQ-013 SAVE_STATUS data SHALL equal latched mstatus with bit7=old bit3, bit3=0, bits[12:11]=2'b11.
REQ-014 Trap redirect PC SHALL be {i_mtvec[31:2],2'b00}, or TRAP_ADDRESS when i_mtvec[31:2]==0, subject to REQ-021.
REQ-015 On mret in cycle N: RESTORE_STATUS(N+1) writes sel 3 with bit3=old bit7, bit7=1, bits[12:11]=2'b11; redirect PC = i_mepc sampled at N.
REQ-016 REDIRECT SHALL hold o_redirect_valid=1 and o_redirect_pc stable until i_redirect_ack=1; ack in that same cycle returns to IDLE next cycle; ack outside REDIRECT SHALL be ignored.
REQ-017 While not IDLE, all exception, interrupt and mret inputs SHALL be ignored (no queuing).
REQ-018 Trap entry latency SHALL be 5 cycles from detection to o_redirect_valid; mret latency 2 cycles.

Reset
REQ-019 i_rst=1 SHALL asynchronously force IDLE, o_busy=0, o_csr_wr_en=0, o_csr_wr_sel=0, o_csr_wr_data=0, o_redirect_valid=0, o_redirect_pc=0, all latches 0, including mid-sequence.
REQ-020 First request SHALL be accepted on the first rising edge after i_rst deasserts.

Configuration
REQ-021 Macro ASRV32_VECTORED_TRAP_EN defined: for interrupts with i_mtvec[1:0]==2'b01, redirect PC SHALL be base + 4*code (32-bit wrap); exceptions use base. Undefined: i_mtvec[1:0] ignored, always direct mode.

Verification
REQ-022 Illegal at i_pc=0x100, i_instr=0xFFFFFFFF, mtvec=0x200 -> writes MEPC=0x100, MCAUSE=0x2, MTVAL=0xFFFFFFFF, MSTATUS, redirect 0x200 at N+5.
REQ-023 Load_mis + MEI simultaneously, mstatus=0x8 -> MCAUSE=0x4, MTVAL=i_bad_addr, MSTATUS write=0x1880.
REQ-024 MTI, mtvec=0x201, macro defined -> redirect 0x21C; macro undefined -> 0x200; mstatus[3]=0 -> no trap.
REQ-025 mret with mstatus=0x1880, mepc=0x104 -> MSTATUS write=0x1888, redirect 0x104 at N+2; ack delayed 3 cycles -> valid and PC held.
REQ-026 i_rst asserted during SAVE_CAUSE -> all outputs 0 immediately, no further writes; new ecall after release -> MCAUSE=0xB.

Source files
------------

// File: rtl/asrv32_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : asrv32_trap_ctrl
// Description : Machine-mode trap/mret sequencer. Writes MEPC, MCAUSE, MTVAL
//               and MSTATUS one per cycle, then redirects fetch until acked.
//               Optional macro ASRV32_VECTORED_TRAP_EN enables vectored
//               interrupt dispatch when mtvec[1:0]==2'b01.
// Revision    : 1.0 - initial release
// ============================================================================
module asrv32_trap_ctrl #(
    parameter logic [31:0] TRAP_ADDRESS = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stage_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    input  logic        i_exc_inst_mis,
    input  logic        i_exc_illegal,
    input  logic        i_exc_ebreak,
    input  logic        i_exc_ecall,
    input  logic        i_exc_load_mis,
    input  logic        i_exc_store_mis,
    input  logic [31:0] i_bad_addr,
    input  logic        i_is_mret,
    input  logic [2:0]  i_irq,
    input  logic [2:0]  i_mie,
    input  logic [31:0] i_mstatus,
    input  logic [31:0] i_mtvec,
    input  logic [31:0] i_mepc,
    output logic        o_busy,
    output logic        o_csr_wr_en,
    output logic [1:0]  o_csr_wr_sel,
    output logic [31:0] o_csr_wr_data,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ack
);

    typedef enum logic [2:0] {
        S_IDLE           = 3'd0,
        S_SAVE_EPC       = 3'd1,
        S_SAVE_CAUSE     = 3'd2,
        S_SAVE_TVAL      = 3'd3,
        S_SAVE_STATUS    = 3'd4,
        S_RESTORE_STATUS = 3'd5,
        S_REDIRECT       = 3'd6
    } state_e;

    localparam logic [1:0] SEL_MEPC    = 2'd0;
    localparam logic [1:0] SEL_MCAUSE  = 2'd1;
    localparam logic [1:0] SEL_MTVAL   = 2'd2;
    localparam logic [1:0] SEL_MSTATUS = 2'd3;

    state_e      state_q;
    logic        int_q;
    logic [3:0]  code_q;
    logic [31:0] tval_q;
    logic [31:0] mstatus_q;
    logic [31:0] target_q;

    logic [2:0]  w_irq_pend;
    logic        w_irq_take;
    logic        w_trap;
    logic        w_mret;
    logic        w_int;
    logic [3:0]  w_code;
    logic [31:0] w_tval;
    logic [31:0] w_base;
    logic [31:0] w_target;

    // Trap entry: MIE -> MPIE, clear MIE, MPP = M.
    function automatic logic [31:0] trap_status(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[7]     = s[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_status(input logic [31:0] s);
        logic [31:0] r;
        r        = s;
        r[3]     = s[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

    always_comb begin
        w_irq_pend = i_irq & i_mie;
        w_irq_take = i_mstatus[3] & (|w_irq_pend);
        w_trap     = 1'b1;
        w_int      = 1'b0;
        w_code     = 4'd0;
        w_tval     = 32'd0;
        if (i_exc_inst_mis) begin
            w_code = 4'd0;
            w_tval = i_bad_addr;
        end else if (i_exc_illegal) begin
            w_code = 4'd2;
            w_tval = i_instr;
        end else if (i_exc_ebreak) begin
            w_code = 4'd3;
        end else if (i_exc_ecall) begin
            w_code = 4'd11;
        end else if (i_exc_load_mis) begin
            w_code = 4'd4;
            w_tval = i_bad_addr;
        end else if (i_exc_store_mis) begin
            w_code = 4'd6;
            w_tval = i_bad_addr;
        end else if (w_irq_take) begin
            // irq vector order is {meip, mtip, msip}; MEI > MSI > MTI
            w_int = 1'b1;
            if (w_irq_pend[2]) begin
                w_code = 4'd11;
            end else if (w_irq_pend[0]) begin
                w_code = 4'd3;
            end else begin
                w_code = 4'd7;
            end
        end else begin
            w_trap = 1'b0;
        end
        w_mret = i_is_mret & ~w_trap;
    end

    assign w_base = (i_mtvec[31:2] == 30'd0) ? TRAP_ADDRESS : {i_mtvec[31:2], 2'b00};

`ifdef ASRV32_VECTORED_TRAP_EN
    assign w_target = (w_int && (i_mtvec[1:0] == 2'b01))
                    ? (w_base + {26'd0, w_code, 2'b00}) : w_base;
`else
    logic w_unused_mtvec_mode;
    assign w_unused_mtvec_mode = &{1'b0, i_mtvec[1:0]};
    assign w_target = w_base;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q          <= S_IDLE;
            int_q            <= 1'b0;
            code_q           <= 4'd0;
            tval_q           <= 32'd0;
            mstatus_q        <= 32'd0;
            target_q         <= 32'd0;
            o_busy           <= 1'b0;
            o_csr_wr_en      <= 1'b0;
            o_csr_wr_sel     <= SEL_MEPC;
            o_csr_wr_data    <= 32'd0;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= 32'd0;
        end else begin
            o_csr_wr_en <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_stage_valid && w_trap) begin
                        int_q         <= w_int;
                        code_q        <= w_code;
                        tval_q        <= w_tval;
                        mstatus_q     <= i_mstatus;
                        target_q      <= w_target;
                        o_busy        <= 1'b1;
                        o_csr_wr_en   <= 1'b1;
                        o_csr_wr_sel  <= SEL_MEPC;
                        o_csr_wr_data <= i_pc;
                        state_q       <= S_SAVE_EPC;
                    end else if (i_stage_valid && w_mret) begin
                        mstatus_q     <= i_mstatus;
                        target_q      <= i_mepc;
                        o_busy        <= 1'b1;
                        o_csr_wr_en   <= 1'b1;
                        o_csr_wr_sel  <= SEL_MSTATUS;
                        o_csr_wr_data <= mret_status(i_mstatus);
                        state_q       <= S_RESTORE_STATUS;
                    end
                end
                S_SAVE_EPC: begin
                    o_csr_wr_en   <= 1'b1;
                    o_csr_wr_sel  <= SEL_MCAUSE;
                    o_csr_wr_data <= {int_q, 27'd0, code_q};
                    state_q       <= S_SAVE_CAUSE;
                end
                S_SAVE_CAUSE: begin
                    o_csr_wr_en   <= 1'b1;
                    o_csr_wr_sel  <= SEL_MTVAL;
                    o_csr_wr_data <= tval_q;
                    state_q       <= S_SAVE_TVAL;
                end
                S_SAVE_TVAL: begin
                    o_csr_wr_en   <= 1'b1;
                    o_csr_wr_sel  <= SEL_MSTATUS;
                    o_csr_wr_data <= trap_status(mstatus_q);
                    state_q       <= S_SAVE_STATUS;
                end
                S_SAVE_STATUS, S_RESTORE_STATUS: begin
                    o_redirect_valid <= 1'b1;
                    o_redirect_pc    <= target_q;
                    state_q          <= S_REDIRECT;
                end
                S_REDIRECT: begin
                    if (i_redirect_ack) begin
                        o_redirect_valid <= 1'b0;
                        o_busy           <= 1'b0;
                        state_q          <= S_IDLE;
                    end
                end
                default: begin
                    o_busy           <= 1'b0;
                    o_redirect_valid <= 1'b0;
                    state_q          <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
